// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   IF-stage producer for the IF/ID pipeline register. Owns the fetch PC and
//   fetches instruction words over a req/gnt + rvalid handshake, keeping at
//   most one request outstanding. Returned words are buffered in a small FIFO
//   whose head is presented to IF/ID. A redirect from EX clears the FIFO,
//   retargets the PC and discards any word still in flight.
//
// Ports
//   clk, reset            clock (rising edge); asynchronous active-low reset
//   hold                  IF/ID stall, head entry is not consumed while high
//   redirect, redirect_pc taken branch/jump pulse and target (bits [1:0] ignored)
//   imem_req, imem_addr   fetch request (held until imem_gnt) and its address
//   imem_gnt              memory accepted the request
//   imem_rvalid, imem_rdata  read data return, once per grant
//   Instruction, PC_IF    FIFO head word and its PC (0 when FIFO empty)
//   flush_IFID            FIFO empty or redirect: IF/ID loads a bubble
//
// Optional feature (macro IFETCH_PERF_CNT_EN)
//   Adds perf_fetch_cnt (words pushed) and perf_bubble_cnt (cycles with
//   flush_IFID=1 and hold=0); both wrap.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC_IF,
    output logic        flush_IFID
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    localparam int              PW      = $clog2(BUF_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   buf_pc_q  [BUF_DEPTH];
    logic [31:0]   buf_pc_d  [BUF_DEPTH];
    logic [31:0]   buf_ins_q [BUF_DEPTH];
    logic [31:0]   buf_ins_d [BUF_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] count_post_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;

    // FIFO status, push/pop qualification and occupancy after this cycle
    always_comb begin
        empty_s      = (count_q == {CW{1'b0}});
        // a word returning in the redirect cycle is wrong-path and is dropped
        push_s       = (state_q == S_WAIT) && imem_rvalid && !redirect;
        pop_s        = !empty_s && !hold && !redirect;
        count_post_s = count_q;
        if (push_s && !pop_s) begin
            count_post_s = count_q + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_post_s = count_q - CNT_ONE;
        end else begin
            count_post_s = count_q;
        end
    end

    // Fetch FSM next state plus fetch/request PC bookkeeping
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (redirect || (count_q < DEPTH_C)) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (imem_gnt) begin
                    // granted wrong-path request must still be drained
                    state_d = redirect ? S_DRAIN : S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect || (count_post_s < DEPTH_C)) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (redirect) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if ((state_q == S_REQ) && imem_gnt) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        if ((state_q == S_REQ) && imem_gnt) begin
            req_pc_d = fetch_pc_q;
        end else begin
            req_pc_d = req_pc_q;
        end
    end

    // FIFO storage and pointer updates; a redirect empties the FIFO
    always_comb begin
        buf_pc_d  = buf_pc_q;
        buf_ins_d = buf_ins_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (redirect) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                buf_pc_d[wr_ptr_q]  = req_pc_q;
                buf_ins_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d            = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_post_s;
        end
    end

    // State, PC and FIFO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc_q[i]  <= 32'h0000_0000;
                buf_ins_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            buf_pc_q   <= buf_pc_d;
            buf_ins_q  <= buf_ins_d;
        end
    end

    // imem_addr only moves on grant or redirect, so it is stable while requesting
    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = fetch_pc_q;
    assign Instruction = empty_s ? 32'h0000_0000 : buf_ins_q[rd_ptr_q];
    assign PC_IF       = empty_s ? 32'h0000_0000 : buf_pc_q[rd_ptr_q];
    assign flush_IFID  = empty_s | redirect;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0] perf_bubble_cnt_q, perf_bubble_cnt_d;

    // Performance counter increments
    always_comb begin
        if (push_s) begin
            perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
        end else begin
            perf_fetch_cnt_d = perf_fetch_cnt_q;
        end
        if (flush_IFID && !hold) begin
            perf_bubble_cnt_d = perf_bubble_cnt_q + 32'd1;
        end else begin
            perf_bubble_cnt_d = perf_bubble_cnt_q;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt_q  <= 32'h0000_0000;
            perf_bubble_cnt_q <= 32'h0000_0000;
        end else begin
            perf_fetch_cnt_q  <= perf_fetch_cnt_d;
            perf_bubble_cnt_q <= perf_bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = perf_fetch_cnt_q;
    assign perf_bubble_cnt = perf_bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit. A memory model answers requests
//   with configurable grant delay and read latency. Every granted fetch pushes
//   its expected {PC, word} into a scoreboard queue (the PC comes from the
//   bench's own fetch-PC model); redirects and resets flush that queue. Words
//   are popped and compared as IF/ID consumes them.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hold;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] PC_IF;
    logic        flush_IFID;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Instruction (Instruction),
        .PC_IF       (PC_IF),
        .flush_IFID  (flush_IFID)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } sb_t;

    sb_t         sb_q [$];
    int          n_vis;          // scoreboard entries already visible at the FIFO head side
    logic [31:0] exp_fetch_pc;
    bit          mem_busy;
    bit          mem_live;       // in-flight word still expected to reach the FIFO
    int          mem_lat;
    logic [31:0] mem_addr_lat;
    int          lat_cfg;
    int          gnt_wait_cfg;
    int          req_wait;
    int          cnt_push;
    int          cnt_bubble;
    int          n_checks;
    int          n_fail;
    bit          found;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive inputs on the falling edge, run memory model, check.
    task automatic cycle(input logic h, input logic r, input logic [31:0] rpc);
        sb_t  e;
        logic exp_flush;
        logic rv_now;
        logic gnt_now;
        @(negedge clk);
        hold        = h;
        redirect    = r;
        redirect_pc = rpc;
        rv_now = mem_busy && (mem_lat == 0);
        imem_rvalid = rv_now;
        imem_rdata  = rv_now ? mem_word(mem_addr_lat) : 32'hDEAD_BEEF;
        if (rv_now) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_lat--;
        end
        gnt_now  = imem_req && !mem_busy && reset && (req_wait >= gnt_wait_cfg);
        imem_gnt = gnt_now;
        if (imem_req && !gnt_now) req_wait++;
        else req_wait = 0;
        #1;
        if (reset) begin
            exp_flush = (n_vis == 0) || r;
            check_val("flush_IFID", {31'd0, flush_IFID}, {31'd0, exp_flush});
            if (n_vis > 0) begin
                check_val("PC_IF", PC_IF, sb_q[0].pc);
                check_val("Instruction", Instruction, sb_q[0].ins);
            end else begin
                check_val("PC_IF_empty", PC_IF, 32'd0);
                check_val("Instruction_empty", Instruction, 32'd0);
            end
            if (n_vis == DEPTH) check_val("req_when_full", {31'd0, imem_req}, 32'd0);
            if ((n_vis > 0) && !h && !r) begin
                void'(sb_q.pop_front());
                n_vis--;
            end
            if (exp_flush && !h) cnt_bubble++;
            if (rv_now && mem_live) begin
                if (!r) begin
                    n_vis++;
                    cnt_push++;
                end
                mem_live = 1'b0;
            end
            if (gnt_now) begin
                check_val("imem_addr", imem_addr, exp_fetch_pc);
                e.pc  = exp_fetch_pc;
                e.ins = mem_word(exp_fetch_pc);
                sb_q.push_back(e);
                exp_fetch_pc = exp_fetch_pc + 32'd4;
                mem_busy     = 1'b1;
                mem_live     = 1'b1;
                mem_lat      = lat_cfg;
                mem_addr_lat = imem_addr;
            end
            if (r) begin
                sb_q.delete();
                n_vis        = 0;
                mem_live     = 1'b0;
                exp_fetch_pc = rpc & 32'hFFFF_FFFC;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check_val("rst_req", {31'd0, imem_req}, 32'd0);
        check_val("rst_addr", imem_addr, RESET_PC);
        check_val("rst_flush", {31'd0, flush_IFID}, 32'd1);
        check_val("rst_pc_if", PC_IF, 32'd0);
        check_val("rst_instr", Instruction, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        check_val("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check_val("rst_perf_bubble", perf_bubble_cnt, 32'd0);
`endif
        sb_q.delete();
        n_vis        = 0;
        mem_live     = 1'b0;
        exp_fetch_pc = RESET_PC;
        cnt_push     = 0;
        cnt_bubble   = 0;
        req_wait     = 0;
    endtask

    task automatic perf_check();
`ifdef IFETCH_PERF_CNT_EN
        @(posedge clk);
        #1;
        check_val("perf_fetch_cnt", perf_fetch_cnt, cnt_push);
        check_val("perf_bubble_cnt", perf_bubble_cnt, cnt_bubble);
`endif
    endtask

    initial begin
        hold = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        n_vis = 0; exp_fetch_pc = RESET_PC; mem_busy = 1'b0; mem_live = 1'b0;
        mem_lat = 0; mem_addr_lat = 32'd0; lat_cfg = 0; gnt_wait_cfg = 0;
        req_wait = 0; cnt_push = 0; cnt_bubble = 0; n_checks = 0; n_fail = 0;

        #2;
        apply_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // 1: zero-wait memory, straight-line fetch
        for (int i = 0; i < 24; i++) cycle(1'b0, 1'b0, 32'd0);
        perf_check();

        // 2: long hold fills the FIFO, then release
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 32'd0);

        // 3: redirect while a fetch is outstanding
        lat_cfg = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_busy && mem_live && (mem_lat > 0)) found = 1'b1;
            else cycle(1'b0, 1'b0, 32'd0);
        end
        check_val("t3_reach_wait", {31'd0, found}, 32'd1);
        cycle(1'b0, 1'b1, 32'h0000_0103);
        @(posedge clk);
        #1;
        check_val("t3_drain_noreq", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 32'd0);

        // 4: redirect coinciding with rvalid and a would-be pop
        lat_cfg = 1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_busy && mem_live && (mem_lat == 0) && (n_vis > 0)) found = 1'b1;
            else cycle(1'b1, 1'b0, 32'd0);
        end
        check_val("t4_reach", {31'd0, found}, 32'd1);
        cycle(1'b0, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 32'd0);

        // PC wrap at the top of the address space
        lat_cfg = 0;
        cycle(1'b0, 1'b1, 32'hFFFF_FFF9);
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 32'd0);

        // 5: reset while waiting, then again while requesting; late rvalid ignored
        lat_cfg = 8;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_busy && mem_live && (mem_lat >= 6)) found = 1'b1;
            else cycle(1'b0, 1'b0, 32'd0);
        end
        check_val("t5_reach", {31'd0, found}, 32'd1);
        apply_reset();
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        reset = 1'b1;
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        check_val("t5_req_before_rst", {31'd0, imem_req}, 32'd1);
        apply_reset();
        cycle(1'b0, 1'b0, 32'd0);
        reset = 1'b1;
        lat_cfg = 0;
        for (int i = 0; i < 24; i++) cycle(1'b0, 1'b0, 32'd0);
        perf_check();

        // Random mix of latency, grant delay, hold and redirects
        for (int i = 0; i < 300; i++) begin
            lat_cfg      = $urandom_range(0, 2);
            gnt_wait_cfg = $urandom_range(0, 2);
            cycle(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                  $urandom());
        end
        // 6: counter totals since the last reset
        perf_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
